// File: rtl/eth_crc32_engine_if.sv
// ---------------------------------------------------------------------------
// eth_crc32_engine_if
//   Bundles the frame stream and result handshake of eth_crc32_engine.
//   DATA_BYTES must match the engine instance it is connected to.
//
//   Stream  : s_data, s_keep, s_valid, s_last, check_en (source -> engine)
//             s_ready                                   (engine -> source)
//   Result  : res_valid, crc_out, res_check, res_ok, err_cnt (engine -> sink)
//             res_ready                                 (sink -> engine)
//
//   Handshake rule (both channels): a transfer happens on the rising clk edge
//   where valid && ready are both high. The engine never lowers res_valid
//   or changes the result fields until that transfer. The source may insert
//   idle cycles (s_valid low) at any time.
//
//   modport master : frame source / result consumer side
//   modport slave  : the CRC engine side
// ---------------------------------------------------------------------------
interface eth_crc32_engine_if #(
  parameter int DATA_BYTES = 4
);
  localparam int DW = DATA_BYTES * 8;

  logic [DW-1:0]         s_data;
  logic [DATA_BYTES-1:0] s_keep;
  logic                  s_valid;
  logic                  s_last;
  logic                  s_ready;
  logic                  check_en;

  logic                  res_valid;
  logic                  res_ready;
  logic [31:0]           crc_out;
  logic                  res_check;
  logic                  res_ok;
  logic [15:0]           err_cnt;

  modport master (
    output s_data, s_keep, s_valid, s_last, check_en, res_ready,
    input  s_ready, res_valid, crc_out, res_check, res_ok, err_cnt
  );

  modport slave (
    input  s_data, s_keep, s_valid, s_last, check_en, res_ready,
    output s_ready, res_valid, crc_out, res_check, res_ok, err_cnt
  );
endinterface

// File: rtl/eth_crc32_engine.sv
// ---------------------------------------------------------------------------
// eth_crc32_engine
//   Ethernet CRC-32 (reflected poly 0xEDB88320, init 0xFFFFFFFF, final
//   inversion) over 1..8 bytes per clock. Generate mode reports the FCS;
//   check mode additionally compares the residue of a frame that carries
//   its own FCS against 0xDEBB20E3.
//
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     bus         : eth_crc32_engine_if.slave (stream in, result out)
//     dbg_state   : current FSM state (0 IDLE, 1 ACCUM, 2 HOLD)
//
//   Build option: define CRC_ERR_CNT_EN to get a saturating 16-bit count of
//   check-mode frames whose residue failed; otherwise err_cnt is constant 0.
//
//   All result outputs are decoded directly from flops, so they are glitch
//   free and stable for as long as the state sits in HOLD.
// ---------------------------------------------------------------------------
module eth_crc32_engine #(
  parameter int DATA_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  eth_crc32_engine_if.slave      bus,
  output logic [1:0]             dbg_state
);

  localparam logic [31:0] POLY     = 32'hEDB88320;
  localparam logic [31:0] INIT     = 32'hFFFFFFFF;
  localparam logic [31:0] RESIDUE  = 32'hDEBB20E3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                state;
  logic [31:0]           crc_reg;
  logic                  res_check_q;
  logic [DATA_BYTES-1:0] lane_en;
  logic [31:0]           crc_seed;
  logic [31:0]           crc_next;
  logic                  accept;

  // One byte, LSB first, through the reflected LFSR.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int b = 0; b < 8; b++) begin
      if (r[0] ^ d[b]) r = (r >> 1) ^ POLY;
      else             r = r >> 1;
    end
    return r;
  endfunction

  assign accept = bus.s_valid && bus.s_ready;

  always_comb begin
    // Keep only matters on the last beat; an all-zero keep still carries
    // one byte so a malformed last beat cannot produce an empty update.
    lane_en = '1;
    if (bus.s_last) begin
      lane_en = (bus.s_keep == '0) ? DATA_BYTES'(1) : bus.s_keep;
    end
    // The first beat always starts from INIT, never from whatever crc_reg holds.
    crc_seed = (state == IDLE) ? INIT : crc_reg;
    crc_next = crc_seed;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (lane_en[i]) crc_next = crc_byte(crc_next, bus.s_data[8*i +: 8]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      crc_reg     <= INIT;
      res_check_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            crc_reg     <= crc_next;
            res_check_q <= bus.check_en;
            state       <= bus.s_last ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            crc_reg <= crc_next;
            if (bus.s_last) state <= HOLD;
          end
        end
        HOLD: begin
          if (bus.res_ready) begin
            state   <= IDLE;
            crc_reg <= INIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.s_ready   = (state != HOLD);
  assign bus.res_valid = (state == HOLD);
  assign bus.crc_out   = ~crc_reg;
  assign bus.res_check = res_check_q;
  assign bus.res_ok    = (state == HOLD) && res_check_q && (crc_reg == RESIDUE);
  assign dbg_state     = state;

`ifdef CRC_ERR_CNT_EN
  logic [15:0] err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 16'h0000;
    end else if (bus.res_valid && bus.res_ready && res_check_q && !bus.res_ok
                 && (err_q != 16'hFFFF)) begin
      err_q <= err_q + 16'h0001;
    end
  end

  assign bus.err_cnt = err_q;
`else
  assign bus.err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_eth_crc32_engine.sv
module tb_eth_crc32_engine;

  localparam int DB = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  eth_crc32_engine_if #(.DATA_BYTES(DB)) bus4 ();
  eth_crc32_engine_if #(.DATA_BYTES(1))  bus1 ();
  logic [1:0] dbg4;
  logic [1:0] dbg1;

  eth_crc32_engine #(.DATA_BYTES(DB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus4),
    .dbg_state (dbg4)
  );

  eth_crc32_engine #(.DATA_BYTES(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus1),
    .dbg_state (dbg1)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [33:0] exp_q[$];          // {check, ok, crc}
  logic [7:0]  fb[$];             // frame under construction
  logic [31:0] tbl[256];
  logic [15:0] exp_err = 16'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (table-driven CRC) ----------------
  task automatic build_table();
    logic [31:0] c;
    for (int i = 0; i < 256; i++) begin
      c = 32'(i);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      tbl[i] = c;
    end
  endtask

  function automatic logic [31:0] crc_raw(input int len);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < len; i++) c = tbl[c[7:0] ^ fb[i]] ^ (c >> 8);
    return c;
  endfunction

  // A check-mode frame is good when its trailing 4 bytes are the FCS of the rest.
  function automatic logic model_ok(input logic check);
    int n;
    logic [31:0] trail;
    n = fb.size();
    if (!check || n < 4) return 1'b0;
    trail = {fb[n-1], fb[n-2], fb[n-3], fb[n-4]};
    return trail == ~crc_raw(n - 4);
  endfunction

  task automatic load_check_vector();
    fb.delete();
    for (int i = 0; i < 9; i++) fb.push_back(8'(49 + i));
  endtask

  task automatic make_frame(input logic check);
    int n;
    logic [31:0] f;
    int pos;
    fb.delete();
    if (!check) begin
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
    end else begin
      n = $urandom_range(1, 16);
      for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
      f = ~crc_raw(n);
      for (int i = 0; i < 4; i++) fb.push_back(f[8*i +: 8]);
      if ($urandom_range(0, 1) == 1) begin
        pos = $urandom_range(0, fb.size() - 1);
        fb[pos] = fb[pos] ^ (8'h01 << $urandom_range(0, 7));
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_frame(input logic check, input logic gaps);
    int idx;
    int n;
    int nb;
    logic [DB*8-1:0] d;
    logic [DB-1:0]   k;
    n = fb.size();
    exp_q.push_back({check, model_ok(check), ~crc_raw(n)});
    idx = 0;
    while (idx < n) begin
      @(negedge clk);
      bus4.check_en = (idx == 0) ? check : 1'($urandom_range(0, 1));
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus4.s_valid = 1'b0;
        bus4.s_data  = DB*8'($urandom);
        continue;
      end
      nb = (n - idx < DB) ? (n - idx) : DB;
      for (int l = 0; l < DB; l++) begin
        d[8*l +: 8] = (l < nb) ? fb[idx + l] : 8'($urandom);
        k[l]        = (l < nb);
      end
      bus4.s_last = (idx + DB >= n);
      if (!bus4.s_last) k = DB'($urandom);
      else if (nb == 1 && $urandom_range(0, 1) == 1) k = '0;
      bus4.s_data  = d;
      bus4.s_keep  = k;
      bus4.s_valid = 1'b1;
      chk("s_ready_beat", 32'(bus4.s_ready), 32'd1);
      idx += DB;
    end
    @(negedge clk);
    bus4.s_valid = 1'b0;
    bus4.s_last  = 1'b0;
    chk("latency_res_valid", 32'(bus4.res_valid), 32'd1);
  endtask

  task automatic get_result(input int hold);
    logic [33:0] e;
    logic [31:0] c0;
    logic        ok0;
    int n;
    n = 0;
    while (bus4.res_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("res_valid_wait", 32'(bus4.res_valid), 32'd1);
    if (exp_q.size() == 0) begin
      chk("exp_q_empty", 32'(exp_q.size()), 32'd1);
      return;
    end
    e = exp_q.pop_front();
    chk("crc_out",   bus4.crc_out,          e[31:0]);
    chk("res_check", 32'(bus4.res_check),   32'(e[33]));
    chk("res_ok",    32'(bus4.res_ok),      32'(e[32]));
    c0  = bus4.crc_out;
    ok0 = bus4.res_ok;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid",   32'(bus4.res_valid), 32'd1);
      chk("hold_s_ready", 32'(bus4.s_ready),   32'd0);
      chk("hold_crc",     bus4.crc_out,        c0);
      chk("hold_ok",      32'(bus4.res_ok),    32'(ok0));
    end
    bus4.res_ready = 1'b1;
    @(negedge clk);
    bus4.res_ready = 1'b0;
`ifdef CRC_ERR_CNT_EN
    if (e[33] && !e[32] && exp_err != 16'hFFFF) exp_err = exp_err + 16'h1;
`endif
    chk("post_hs_valid",   32'(bus4.res_valid), 32'd0);
    chk("post_hs_s_ready", 32'(bus4.s_ready),   32'd1);
    chk("err_cnt",         32'(bus4.err_cnt),   32'(exp_err));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_s_ready"},   32'(bus4.s_ready),   32'd1);
    chk({tag, "_res_valid"}, 32'(bus4.res_valid), 32'd0);
    chk({tag, "_res_check"}, 32'(bus4.res_check), 32'd0);
    chk({tag, "_res_ok"},    32'(bus4.res_ok),    32'd0);
    chk({tag, "_err_cnt"},   32'(bus4.err_cnt),   32'd0);
    chk({tag, "_crc_out"},   bus4.crc_out,        32'h0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    bus4.s_data = '0; bus4.s_keep = '0; bus4.s_valid = 1'b0; bus4.s_last = 1'b0;
    bus4.check_en = 1'b0; bus4.res_ready = 1'b0;
    bus1.s_data = '0; bus1.s_keep = '0; bus1.s_valid = 1'b0; bus1.s_last = 1'b0;
    bus1.check_en = 1'b0; bus1.res_ready = 1'b0;
    build_table();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("reset");

    // Known vector, generate mode, no gaps then with gaps.
    load_check_vector();
    send_frame(1'b0, 1'b0);
    chk("kv_gen", bus4.crc_out, 32'hCBF43926);
    get_result(0);
    load_check_vector();
    send_frame(1'b0, 1'b1);
    chk("kv_gen_gaps", bus4.crc_out, 32'hCBF43926);
    get_result(0);

    // Check mode with the correct FCS appended, then with a flipped data bit.
    load_check_vector();
    fb.push_back(8'h26); fb.push_back(8'h39); fb.push_back(8'hF4); fb.push_back(8'hCB);
    send_frame(1'b1, 1'b0);
    chk("kv_check_ok", 32'(bus4.res_ok), 32'd1);
    get_result(0);
    fb[0] = fb[0] ^ 8'h01;
    send_frame(1'b1, 1'b0);
    chk("kv_check_bad", 32'(bus4.res_ok), 32'd0);
    get_result(0);

    // Result backpressure, then a frame that must start from a fresh init.
    make_frame(1'b0);
    send_frame(1'b0, 1'b0);
    get_result(5);
    load_check_vector();
    send_frame(1'b0, 1'b0);
    chk("after_bp", bus4.crc_out, 32'hCBF43926);
    get_result(0);

    // Random frames: random mode, length, gaps, keep=0 corner and backpressure.
    for (int f = 0; f < 40; f++) begin
      logic m;
      m = 1'($urandom_range(0, 1));
      make_frame(m);
      send_frame(m, 1'($urandom_range(0, 1)));
      get_result($urandom_range(0, 3));
    end

    // Reset in the middle of a frame.
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      bus4.s_data   = DB*8'($urandom);
      bus4.s_keep   = '1;
      bus4.s_last   = 1'b0;
      bus4.check_en = 1'b1;
      bus4.s_valid  = 1'b1;
    end
    @(negedge clk);
    bus4.s_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    exp_err = 16'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    load_check_vector();
    send_frame(1'b0, 1'b0);
    chk("after_reset", bus4.crc_out, 32'hCBF43926);
    get_result(0);

    // One byte per beat on the narrow instance.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus1.s_data  = 8'(49 + i);
      bus1.s_keep  = 1'b1;
      bus1.s_last  = (i == 8);
      bus1.s_valid = 1'b1;
    end
    @(negedge clk);
    bus1.s_valid = 1'b0;
    bus1.s_last  = 1'b0;
    chk("db1_latency", 32'(bus1.res_valid), 32'd1);
    chk("db1_crc",     bus1.crc_out,        32'hCBF43926);
    bus1.res_ready = 1'b1;
    @(negedge clk);
    bus1.res_ready = 1'b0;
    chk("db1_released", 32'(bus1.res_valid), 32'd0);
    chk("db1_s_ready",  32'(bus1.s_ready),   32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eth_crc32_engine.md
# eth_crc32_engine

Parametrised Ethernet CRC-32 engine that processes 1 to 8 bytes per clock and runs in either generate mode (FCS for TX) or check mode (residue compare for RX). It sits between the MAC framing logic and the byte-lane datapath. Each frame result is held behind a valid/ready handshake, so the TX inserter or RX filter can consume it at its own pace. Frames use a streaming valid/ready/last/keep interface.

## Interface
Parameters:
- DATA_BYTES, 4, bytes per beat; legal 1..8; data width DW = DATA_BYTES*8

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- s_data  input  DW  frame bytes; s_data[7:0] is the earliest byte on the wire
- s_keep  input  DATA_BYTES  valid lanes, contiguous from lane 0; only honoured when s_last=1
- s_valid  input  1  beat valid
- s_last  input  1  final beat of frame
- s_ready  output  1  engine accepts a beat
- check_en  input  1  mode for the frame: 0 = generate, 1 = check; sampled on the first beat
- res_valid  output  1  frame result available
- res_ready  input  1  consumer takes the result
- crc_out  output  32  final FCS (~crc_reg); crc_out[7:0] is transmitted first
- res_check  output  1  captured check_en of the reported frame
- res_ok  output  1  check mode: the residue matched; forced to 0 in generate mode
- err_cnt  output  16  count of bad frames (see Configuration)

## Operation
- CRC: reflected polynomial 0xEDB88320, init 0xFFFFFFFF, final inversion. Bytes are processed in lane order 0..N-1; each byte is processed LSB-first.
- States:
  - IDLE: no frame in progress.
  - ACCUM: at least one beat accepted, last not yet seen.
  - HOLD: result pending.
- Beat acceptance: a beat is accepted when s_valid && s_ready. s_ready = (state != HOLD).
- First accepted beat, IDLE to ACCUM:
  - The beat is computed from the init value 0xFFFFFFFF, regardless of the stale crc_reg.
  - check_en is latched into res_check.
- Intermediate beats (s_last=0): all DATA_BYTES lanes are processed, and s_keep is ignored.
- Last beat:
  - Only lanes with s_keep=1 are processed; s_keep must be contiguous from lane 0.
  - s_keep=0 on every lane is treated as 0x01 (one byte).
  - Next state is HOLD. A single-beat frame goes IDLE to HOLD directly.
- In HOLD:
  - crc_out = ~crc_reg.
  - res_ok = res_check && (crc_reg == 0xDEBB20E3), with the frame including its 4 FCS bytes.
- Leaving HOLD: when res_valid && res_ready, state goes to IDLE and crc_reg is reloaded to 0xFFFFFFFF.
- Multi-byte update: the combinational unrolled per-byte chain must match byte-serial results exactly for any DATA_BYTES.

## Timing
- Reset values:
  - state = IDLE; crc_reg = 0xFFFFFFFF.
  - s_ready = 1; res_valid = 0; res_check = 0; res_ok = 0; err_cnt = 0.
  - crc_out = 0x00000000 (the inversion of the reset crc_reg).
- Latency: res_valid rises on the cycle after the last beat is accepted. One beat is processed per cycle at full throughput.
- Result hold: res_valid, crc_out, res_ok and res_check stay stable until the res_ready handshake.
- Next frame:
  - s_ready returns high on the cycle after the handshake.
  - Back-to-back frames therefore have a minimum 1-cycle bubble when res_ready is held high.
- s_valid low mid-frame: crc_reg and state hold.
- Reset asserted mid-frame or in HOLD: the frame is discarded and all outputs return to their reset values asynchronously.
- check_en changes after the first beat: ignored until the next frame.

## Configuration
- Macro: CRC_ERR_CNT_EN.
- Defined:
  - err_cnt increments by 1, saturating at 0xFFFF, on each result handshake with res_check=1 and res_ok=0.
  - Generate-mode frames never count.
- Undefined: err_cnt is tied to 0 and no counter flops are generated.

## Test plan
- DATA_BYTES=1, generate mode, ASCII "123456789" one byte per beat:
  - res_valid one cycle after the last byte.
  - crc_out = 0xCBF43926.
- DATA_BYTES=4, same 9 bytes as 3 beats, last s_keep = 4'b0001:
  - crc_out = 0xCBF43926.
  - The result is identical with s_valid gaps inserted mid-frame.
- DATA_BYTES=4, check mode, "123456789" followed by bytes 26 39 F4 CB:
  - res_ok = 1.
  - The same frame with one data bit flipped gives res_ok = 0 and err_cnt = 1 (macro defined).
- Result backpressure:
  - Hold res_ready=0 for 5 cycles: s_ready stays 0 and the outputs stay stable.
  - Assert res_ready: res_valid drops, and s_ready = 1 on the next cycle.
  - The next frame's CRC is correct, i.e. it starts from 0xFFFFFFFF.
- Reset mid-frame:
  - Drop rst_n after 2 beats: outputs return to their reset values.
  - A fresh "123456789" frame then yields 0xCBF43926.
- Counter saturation (macro defined): 65537 bad check-mode frames leave err_cnt at 0xFFFF.
